// File: rtl/expr_stim_misr.sv
// LFSR stimulus generator and MISR response compactor for a combinational DUT.
// Each vector is driven for SETTLE+1 cycles and then captured for one cycle.
module expr_stim_misr #(
  parameter logic [63:0] SEED   = 64'h0000_0000_0000_0001,
  parameter int          NVEC   = 256,
  parameter int          SETTLE = 1,
  parameter logic [89:0] POLY   = 90'h27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [89:0] exp_sig,
  input  logic [89:0] y_in,
  output logic [59:0] stim,
  output logic        stim_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [89:0] sig,
  output logic [15:0] vec_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPT,
    DONE
  } state_t;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [63:0] SEED_OK  =
    (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [63:0] TAPS     = 64'hD800_0000_0000_0000;
  localparam logic [3:0]  SETTLE_L = 4'(SETTLE);
  localparam logic [15:0] NVEC_L   = 16'(NVEC);

  state_t      state;
  state_t      state_n;
  logic [63:0] lfsr;
  logic [63:0] lfsr_nx;
  logic [89:0] sig_nx;
  logic [59:0] held;
  logic [3:0]  settle;
  logic [15:0] cnt_inc;
  logic        last_vec;
  logic        launch;

  assign cnt_inc  = vec_cnt + 16'd1;
  assign last_vec = (cnt_inc == NVEC_L);
  assign launch   = start && !abort &&
                    (state == IDLE || state == DONE);

  assign lfsr_nx = {1'b0, lfsr[63:1]} ^
                   (lfsr[0] ? TAPS : 64'h0);
  assign sig_nx  = {sig[88:0], 1'b0} ^
                   (sig[89] ? POLY : 90'h0) ^ y_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE,
        DONE:    if (start) state_n = DRIVE;
        DRIVE:   if (settle == 4'd0) state_n = CAPT;
        CAPT:    state_n = last_vec ? DONE : DRIVE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= SEED_OK;
      sig     <= 90'h0;
      vec_cnt <= 16'h0;
      settle  <= 4'h0;
      held    <= 60'h0;
    end else if (launch) begin
      lfsr    <= SEED_OK;
      sig     <= 90'h0;
      vec_cnt <= 16'h0;
      settle  <= SETTLE_L;
    end else if (!abort) begin
      if (state == DRIVE && settle != 4'd0) begin
        settle <= settle - 4'd1;
      end
      if (state == CAPT) begin
        sig     <= sig_nx;
        lfsr    <= lfsr_nx;
        vec_cnt <= cnt_inc;
        held    <= lfsr[59:0];
        settle  <= SETTLE_L;
      end
    end
  end

  always_comb begin
    stim = 60'h0;
    case (state)
      DRIVE,
      CAPT:    stim = lfsr[59:0];
      DONE:    stim = held;
      default: stim = 60'h0;
    endcase
  end

  assign stim_valid = (state == DRIVE);
  assign busy       = (state == DRIVE) || (state == CAPT);
  assign done       = (state == DONE);
  assign pass       = done && (sig == exp_sig);

endmodule

// File: doc/expr_stim_misr.md
EXPR_STIM_MISR -- requirements
Module: expr_stim_misr

Interface
REQ-001 The block SHALL have parameter SEED, default 64'h0000_0000_0000_0001: the LFSR start value.
REQ-002 The block SHALL have parameter NVEC, default 256, range 1..65535: the number of vectors per run.
REQ-003 The block SHALL have parameter SETTLE, default 1, range 0..15: the extra DUT settle cycles per vector.
REQ-004 The block SHALL have parameter POLY, default 90'h27: the MISR feedback polynomial, low bits.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-006 The block SHALL have port start (in, 1): a one-cycle run request.
REQ-007 The block SHALL have port abort (in, 1): terminates the run and returns to IDLE.
REQ-008 The block SHALL have port exp_sig (in, 90): the golden signature.
REQ-009 The block SHALL have port y_in (in, 90): the packed DUT result bus {y0..y17}.
REQ-010 The block SHALL have port stim (out, 60): the packed DUT operands {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, 4/5/6/4/5/6 bits per side.
REQ-011 The block SHALL have port stim_valid (out, 1): high while stim is being applied (DRIVE).
REQ-012 The block SHALL have port busy (out, 1): high in DRIVE or CAPT.
REQ-013 The block SHALL have port done (out, 1): high in DONE.
REQ-014 The block SHALL have port pass (out, 1): done and sig == exp_sig.
REQ-015 The block SHALL have port sig (out, 90): the current MISR value.
REQ-016 The block SHALL have port vec_cnt (out, 16): the number of vectors captured so far.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE, CAPT and DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to DRIVE with lfsr<=SEED (or 64'h1 if SEED==0), sig<=0, vec_cnt<=0 and settle counter<=SETTLE.
REQ-019 In DRIVE, stim SHALL equal lfsr[59:0], stim_valid SHALL be 1, and the settle counter SHALL decrement each cycle; DRIVE SHALL last exactly SETTLE+1 cycles, then go to CAPT.
REQ-020 In CAPT, stim SHALL hold its value, y_in SHALL be sampled, and these SHALL update:
  - sig <= ({sig[88:0],1'b0} ^ (sig[89] ? POLY : 0)) ^ y_in;
  - lfsr SHALL advance one Galois step with taps 64,63,61,60 (x^64+x^63+x^61+x^60+1);
  - vec_cnt SHALL increment.
REQ-021 CAPT SHALL go to DONE if the incremented vec_cnt equals NVEC, else to DRIVE with settle counter reloaded.
REQ-022 Per-vector latency SHALL be SETTLE+2 cycles; a run SHALL take NVEC*(SETTLE+2) cycles from the start-sampling edge to DONE entry.
REQ-023 start SHALL be ignored while busy.
REQ-024 When abort and start are asserted in the same cycle, abort SHALL win.
REQ-025 abort in any state SHALL go to IDLE next cycle, clearing stim_valid, busy and done; sig and vec_cnt SHALL hold their values.
REQ-026 pass SHALL be combinational from the DONE state and the (sig, exp_sig) comparison; exp_sig changes while in DONE SHALL be reflected the same cycle.
REQ-027 stim SHALL be 0 in IDLE, and in DONE it SHALL hold the last vector driven.
REQ-028 vec_cnt SHALL never exceed NVEC and SHALL NOT wrap.
REQ-029 The LFSR SHALL never reach zero; the seed substitution in REQ-018 guarantees this.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously enter IDLE with stim=0, stim_valid=0, busy=0, done=0, pass=0, sig=0, vec_cnt=0, lfsr=SEED (or 1 if SEED==0), and settle counter=0.
REQ-031 When rst_n is asserted mid-run, the run SHALL be discarded, with no partial signature retained.
REQ-032 On rst_n release, the block SHALL wait in IDLE for start and SHALL ignore start in the release cycle only if that start falls before the first rising edge.

Verification
REQ-033 Reset: assert rst_n=0 mid-DRIVE -> all outputs 0 the same cycle, without a clock edge; state IDLE after release.
REQ-034 NVEC=1, SETTLE=0, y_in=90'h1, start at cycle 0 -> stim_valid high at cycle 1, CAPT at cycle 2, done=1 at cycle 3, sig=90'h1, vec_cnt=1, pass=1 with exp_sig=90'h1.
REQ-035 NVEC=4, SETTLE=1, y_in=0 -> stim sequence of 4 distinct lfsr[59:0] values, each held 3 cycles; done at cycle 13; sig=0.
REQ-036 SEED=0 -> first stim=60'h1; a second vector equal to the 1-step Galois successor of 64'h1, truncated.
REQ-037 start pulsed during a run -> no restart, vec_cnt is monotonic; abort at vector 2 -> IDLE next cycle, vec_cnt=2, done never asserted.
REQ-038 Run completes with exp_sig != sig -> done=1, pass=0; then start from DONE -> sig cleared, new run begins.
